// File: rtl/uc_bus_pkg.sv
// Shared types for the MCU-side cartridge bus master: command opcodes,
// engine states and the latched command record.
package uc_bus_pkg;
  localparam int ADDR_W = 15;

  typedef enum logic [1:0] {
    OP_SETADDR = 2'd0,
    OP_WRITE   = 2'd1,
    OP_READ    = 2'd2,
    OP_NOP     = 2'd3
  } op_e;

  typedef enum logic [3:0] {
    S_IDLE, S_LO_SET, S_LO_STB, S_HI_SET, S_HI_STB,
    S_ACC_REQ, S_ACC_REL, S_INC_STB, S_RSP
  } state_e;

  typedef struct packed {
    op_e               op;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
  } cmd_t;
endpackage

// File: rtl/uc_bus_master_if.sv
// Host command/response stream plus the CPLD pad-side signals of the bus master.
interface uc_bus_master_if;
  import uc_bus_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_wdata;
  logic              rsp_valid;
  logic [7:0]        rsp_data;
  logic              rsp_err;
  logic [7:0]        uc_data_i;
  logic [7:0]        uc_data_o;
  logic              uc_data_oe;
  logic              uc_read;
  logic              uc_write;
  logic              set_addr_lo;
  logic              set_addr_hi;
  logic              strobe_addr;
  logic              uc_ack;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, uc_data_i, uc_ack,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, uc_data_o, uc_data_oe,
           uc_read, uc_write, set_addr_lo, set_addr_hi, strobe_addr
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, uc_data_i, uc_ack,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, uc_data_o, uc_data_oe,
           uc_read, uc_write, set_addr_lo, set_addr_hi, strobe_addr
  );
endinterface

// File: rtl/uc_bus_master_strobe_gen.sv
// Address-strobe timer: SETUP low cycles, STROBE_W high cycles, one hold cycle.
// done is high during the hold cycle. SETUP must be at least 1.
module uc_strobe_gen #(
  parameter int SETUP    = 2,
  parameter int STROBE_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic strobe,
  output logic done
);
  localparam int TOT = SETUP + STROBE_W;
  localparam int CW  = $clog2(TOT + 2);
  localparam logic [CW-1:0] ON_AT   = CW'(SETUP);
  localparam logic [CW-1:0] HOLD_AT = CW'(TOT);

  logic [CW-1:0] cnt, nxt;

  // cnt holds the index of the current cycle within the sequence; the start cycle is 0
  assign nxt = start ? CW'(1) : cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      strobe <= 1'b0;
      done   <= 1'b0;
    end else if (start || cnt != '0) begin
      cnt    <= (nxt > HOLD_AT) ? '0 : nxt;
      strobe <= (nxt >= ON_AT) && (nxt < HOLD_AT);
      done   <= (nxt == HOLD_AT);
    end else begin
      strobe <= 1'b0;
      done   <= 1'b0;
    end
  end
endmodule

// File: rtl/uc_bus_master.sv
// Clocked engine for the CPLD microcontroller port: address loads, strobes and
// the four-phase access handshake. UC_MASTER_AUTOINC_EN skips address loads on hits.
module uc_bus_master
  import uc_bus_pkg::*;
#(
  parameter int SETUP       = 2,
  parameter int STROBE_W    = 2,
  parameter int ACK_TIMEOUT = 1024
) (
  input logic             clk,
  input logic             rst,
  uc_bus_master_if.master bus
);
`ifdef UC_MASTER_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif
  localparam int TMAX = (ACK_TIMEOUT > SETUP) ? ACK_TIMEOUT : SETUP;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] SU_LAST = TW'(SETUP - 1);

  state_e            st;
  cmd_t              cmd, new_cmd;
  logic [ADDR_W-1:0] cur_addr;
  logic              addr_vld, req_up, skip_load;
  logic [TW-1:0]     tmr;
  logic              ack_m, ack_s;
  logic              sg_start, sg_done;

  always_comb begin
    new_cmd.op    = op_e'(bus.cmd_op);
    new_cmd.addr  = bus.cmd_addr;
    new_cmd.wdata = bus.cmd_wdata;
  end

  assign skip_load = AUTOINC && addr_vld && (cur_addr == bus.cmd_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= bus.uc_ack;
      ack_s <= ack_m;
    end
  end

  uc_strobe_gen #(.SETUP(SETUP), .STROBE_W(STROBE_W)) u_stb (
    .clk    (clk),
    .rst    (rst),
    .start  (sg_start),
    .strobe (bus.strobe_addr),
    .done   (sg_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st              <= S_IDLE;
      cmd             <= '0;
      cur_addr        <= '0;
      addr_vld        <= 1'b0;
      req_up          <= 1'b0;
      tmr             <= '0;
      sg_start        <= 1'b0;
      bus.cmd_ready   <= 1'b0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_data    <= '0;
      bus.rsp_err     <= 1'b0;
      bus.uc_data_o   <= '0;
      bus.uc_data_oe  <= 1'b0;
      bus.uc_read     <= 1'b0;
      bus.uc_write    <= 1'b0;
      bus.set_addr_lo <= 1'b0;
      bus.set_addr_hi <= 1'b0;
    end else begin
      sg_start      <= 1'b0;
      bus.rsp_valid <= 1'b0;
      case (st)
        S_IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            bus.cmd_ready <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
            cmd           <= new_cmd;
            if (new_cmd.op == OP_NOP) begin
              st            <= S_RSP;
              bus.rsp_valid <= 1'b1;
            end else if (new_cmd.op != OP_SETADDR && skip_load) begin
              st             <= S_ACC_REQ;
              tmr            <= '0;
              req_up         <= 1'b0;
              bus.uc_data_o  <= new_cmd.wdata;
              bus.uc_data_oe <= (new_cmd.op == OP_WRITE);
            end else begin
              st              <= S_LO_SET;
              sg_start        <= 1'b1;
              bus.uc_data_o   <= new_cmd.addr[7:0];
              bus.uc_data_oe  <= 1'b1;
              bus.set_addr_lo <= 1'b1;
            end
          end else begin
            bus.cmd_ready <= 1'b1;
          end
        end
        S_LO_SET: if (bus.strobe_addr) st <= S_LO_STB;
        S_LO_STB: begin
          if (sg_done) begin
            st              <= S_HI_SET;
            sg_start        <= 1'b1;
            bus.set_addr_lo <= 1'b0;
            bus.set_addr_hi <= 1'b1;
            bus.uc_data_o   <= {1'b0, cmd.addr[14:8]};
          end
        end
        S_HI_SET: if (bus.strobe_addr) st <= S_HI_STB;
        S_HI_STB: begin
          if (sg_done) begin
            bus.set_addr_hi <= 1'b0;
            cur_addr        <= cmd.addr;
            addr_vld        <= 1'b1;
            if (cmd.op == OP_SETADDR) begin
              st             <= S_RSP;
              bus.rsp_valid  <= 1'b1;
              bus.uc_data_oe <= 1'b0;
            end else begin
              // a read releases the pads here, one cycle ahead of uc_read
              st             <= S_ACC_REQ;
              tmr            <= '0;
              req_up         <= 1'b0;
              bus.uc_data_o  <= cmd.wdata;
              bus.uc_data_oe <= (cmd.op == OP_WRITE);
            end
          end
        end
        S_ACC_REQ: begin
          if (!req_up) begin
            if (cmd.op == OP_READ) begin
              bus.uc_read <= 1'b1;
              req_up      <= 1'b1;
              tmr         <= '0;
            end else if (tmr == SU_LAST) begin
              bus.uc_write <= 1'b1;
              req_up       <= 1'b1;
              tmr          <= '0;
            end else begin
              tmr <= tmr + 1'b1;
            end
          end else if (ack_s) begin
            if (cmd.op == OP_READ) bus.rsp_data <= bus.uc_data_i;
            bus.uc_read  <= 1'b0;
            bus.uc_write <= 1'b0;
            st           <= S_ACC_REL;
            tmr          <= '0;
          end else if (tmr == TO_LAST) begin
            bus.uc_read    <= 1'b0;
            bus.uc_write   <= 1'b0;
            bus.uc_data_oe <= 1'b0;
            bus.rsp_data   <= '0;
            bus.rsp_err    <= 1'b1;
            bus.rsp_valid  <= 1'b1;
            addr_vld       <= 1'b0;
            st             <= S_RSP;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_ACC_REL: begin
          if (!ack_s) begin
            st             <= S_INC_STB;
            sg_start       <= 1'b1;
            bus.uc_data_oe <= 1'b0;
          end else if (tmr == TO_LAST) begin
            // the CPLD address may or may not have moved; force a reload next time
            bus.uc_data_oe <= 1'b0;
            bus.rsp_data   <= '0;
            bus.rsp_err    <= 1'b1;
            bus.rsp_valid  <= 1'b1;
            addr_vld       <= 1'b0;
            st             <= S_RSP;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_INC_STB: begin
          if (sg_done) begin
            st            <= S_RSP;
            bus.rsp_valid <= 1'b1;
            cur_addr      <= cur_addr + 1'b1;
          end
        end
        S_RSP: begin
          st            <= S_IDLE;
          bus.cmd_ready <= 1'b1;
        end
        default: st <= S_IDLE;
      endcase
    end
  end
endmodule
